// File: rtl/bp_pkg.sv
// Shared constants and types for the bomberman path checker.
// Optional feature macro: BP_CHK_DOUBLE_JUMP_EN (flags back-to-back jumps).
package bp_pkg;

  localparam int ROWS = 64;
  localparam int COLS = 8;

  localparam logic [5:0] LAST_ROW  = 6'(ROWS - 1);
  localparam logic [5:0] LAST_MOVE = 6'(ROWS - 2);

  localparam logic [1:0] ROAD = 2'd0;
  localparam logic [1:0] LOW  = 2'd1;
  localparam logic [1:0] HIGH = 2'd2;
  localparam logic [1:0] WALL = 2'd3;

  localparam logic [1:0] STAY  = 2'd0;
  localparam logic [1:0] RIGHT = 2'd1;
  localparam logic [1:0] LEFT  = 2'd2;
  localparam logic [1:0] JUMP  = 2'd3;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_WALL = 2'd1;
  localparam logic [1:0] ERR_LOW  = 2'd2;
  localparam logic [1:0] ERR_JUMP = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_REPORT = 3'd4
  } state_t;

endpackage

// File: rtl/bp_path_checker_if.sv
// Map/move input bundle and verdict outputs of the path checker.
interface bp_path_checker_if;

  logic       in_valid;
  logic [2:0] guy;
  logic [1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic       mv_valid;
  logic [1:0] mv;
  logic       out_valid;
  logic       pass;
  logic [5:0] err_step;
  logic [1:0] err_code;

  modport master (
    output in_valid, guy, in0, in1, in2, in3, in4, in5, in6, in7, mv_valid, mv,
    input  out_valid, pass, err_step, err_code
  );

  modport slave (
    input  in_valid, guy, in0, in1, in2, in3, in4, in5, in6, in7, mv_valid, mv,
    output out_valid, pass, err_step, err_code
  );

endinterface

// File: rtl/bp_move_rule.sv
// Combinational legality rule for one move: next column and error code.
// Optional feature macro: BP_CHK_DOUBLE_JUMP_EN adds the previous-move input.
module bp_move_rule
  import bp_pkg::*;
(
  input  logic [2:0]  col,
  input  logic [1:0]  mv,
  input  logic [15:0] row,
`ifdef BP_CHK_DOUBLE_JUMP_EN
  input  logic [1:0]  prev_mv,
`endif
  output logic [2:0]  next_col,
  output logic [1:0]  err
);

  logic       edge_err_s;
  logic [1:0] cell_s;
  logic [1:0] cell_err_s;
  logic       dbl_jump_s;

  // Column step with edge saturation, then target-cell and jump checks.
  always_comb begin
    edge_err_s = 1'b0;
    next_col   = col;
    case (mv)
      RIGHT: begin
        if (col == 3'd7) edge_err_s = 1'b1;
        else             next_col   = col + 3'd1;
      end
      LEFT: begin
        if (col == 3'd0) edge_err_s = 1'b1;
        else             next_col   = col - 3'd1;
      end
      default: next_col = col;
    endcase

    cell_s = row[{next_col, 1'b0} +: 2];
    case (cell_s)
      WALL:    cell_err_s = ERR_WALL;
      LOW:     cell_err_s = (mv != JUMP) ? ERR_LOW : ERR_NONE;
      HIGH:    cell_err_s = (mv == JUMP) ? ERR_JUMP : ERR_NONE;
      default: cell_err_s = ERR_NONE;
    endcase

`ifdef BP_CHK_DOUBLE_JUMP_EN
    dbl_jump_s = (mv == JUMP) && (prev_mv == JUMP);
`else
    dbl_jump_s = 1'b0;
`endif

    if (edge_err_s)                   err = ERR_WALL;
    else if (cell_err_s != ERR_NONE)  err = cell_err_s;
    else if (dbl_jump_s)              err = ERR_JUMP;
    else                              err = ERR_NONE;
  end

endmodule

// File: rtl/bp_path_checker.sv
// Captures a ROWS-row map, replays the planner's move stream and reports one verdict.
// Optional feature macro: BP_CHK_DOUBLE_JUMP_EN (back-to-back jumps flagged as err 3).
module bp_path_checker
  import bp_pkg::*;
(
  input logic              clk,
  input logic              rst,
  bp_path_checker_if.slave bus
);

  state_t      state_r;
  logic [5:0]  row_cnt_r;
  logic [5:0]  mv_cnt_r;
  logic [2:0]  col_r;
  logic [15:0] map_r [ROWS];
  logic        err_seen_r;
  logic [5:0]  err_step_r;
  logic [1:0]  err_code_r;
  logic        out_valid_r;
  logic        pass_r;
  logic [5:0]  step_out_r;
  logic [1:0]  code_out_r;
`ifdef BP_CHK_DOUBLE_JUMP_EN
  logic [1:0]  prev_mv_r;
`endif

  logic [15:0] row_s;
  logic [5:0]  tgt_idx_s;
  logic [2:0]  next_col_s;
  logic [1:0]  rule_err_s;
  logic        new_err_s;

  assign row_s     = {bus.in7, bus.in6, bus.in5, bus.in4, bus.in3, bus.in2, bus.in1, bus.in0};
  assign tgt_idx_s = mv_cnt_r + 6'd1;
  assign new_err_s = (rule_err_s != ERR_NONE);

  bp_move_rule u_rule (
    .col      (col_r),
    .mv       (bus.mv),
    .row      (map_r[tgt_idx_s]),
`ifdef BP_CHK_DOUBLE_JUMP_EN
    .prev_mv  (prev_mv_r),
`endif
    .next_col (next_col_s),
    .err      (rule_err_s)
  );

  // Pattern FSM: map capture, move replay, first-error latch and verdict strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      row_cnt_r   <= 6'd0;
      mv_cnt_r    <= 6'd0;
      col_r       <= 3'd0;
      err_seen_r  <= 1'b0;
      err_step_r  <= 6'd0;
      err_code_r  <= ERR_NONE;
      out_valid_r <= 1'b0;
      pass_r      <= 1'b0;
      step_out_r  <= 6'd0;
      code_out_r  <= ERR_NONE;
`ifdef BP_CHK_DOUBLE_JUMP_EN
      prev_mv_r   <= STAY;
`endif
      for (int k = 0; k < ROWS; k++) map_r[k] <= 16'd0;
    end else begin
      out_valid_r <= 1'b0;
      pass_r      <= 1'b0;
      step_out_r  <= 6'd0;
      code_out_r  <= ERR_NONE;
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            map_r[0]   <= row_s;
            col_r      <= bus.guy;
            row_cnt_r  <= 6'd1;
            mv_cnt_r   <= 6'd0;
            err_seen_r <= 1'b0;
            err_step_r <= 6'd0;
            err_code_r <= ERR_NONE;
`ifdef BP_CHK_DOUBLE_JUMP_EN
            prev_mv_r  <= STAY;
`endif
            state_r    <= ST_LOAD;
          end else begin
            state_r    <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (bus.in_valid) begin
            map_r[row_cnt_r] <= row_s;
            if (row_cnt_r == LAST_ROW) state_r   <= ST_WAIT;
            else                       row_cnt_r <= row_cnt_r + 6'd1;
          end else begin
            state_r <= ST_LOAD;
          end
        end
        // The first move is already evaluated in WAIT so none is lost on the transition.
        ST_WAIT, ST_CHECK: begin
          if (bus.mv_valid) begin
            col_r <= next_col_s;
`ifdef BP_CHK_DOUBLE_JUMP_EN
            prev_mv_r <= bus.mv;
`endif
            if (!err_seen_r && new_err_s) begin
              err_seen_r <= 1'b1;
              err_step_r <= mv_cnt_r;
              err_code_r <= rule_err_s;
            end else begin
              err_seen_r <= err_seen_r;
            end
            if (mv_cnt_r == LAST_MOVE) begin
              state_r     <= ST_REPORT;
              out_valid_r <= 1'b1;
              pass_r      <= !err_seen_r && !new_err_s;
              step_out_r  <= err_seen_r ? err_step_r : (new_err_s ? mv_cnt_r : 6'd0);
              code_out_r  <= err_seen_r ? err_code_r : rule_err_s;
            end else begin
              mv_cnt_r <= mv_cnt_r + 6'd1;
              state_r  <= ST_CHECK;
            end
          end else begin
            state_r <= state_r;
          end
        end
        ST_REPORT: begin
          row_cnt_r <= 6'd0;
          mv_cnt_r  <= 6'd0;
          state_r   <= ST_IDLE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.pass      = pass_r;
  assign bus.err_step  = step_out_r;
  assign bus.err_code  = code_out_r;

endmodule
